// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, wait-counter width, default depth and captured request layout.
package dmem_pkg;

    localparam int unsigned DMEM_CNT_W         = 4;
    localparam int unsigned DMEM_DEPTH_DEFAULT = 8192;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 32-bit word array with per-byte write enables.
// Latency: write and read both complete on the enabled edge; read data holds until the next read.
// Backpressure: none, driven for exactly one edge per transaction by the responder.
module dmem_array #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked load/store responder with WAIT_CYCLES wait states; optional byte strobes via DMEM_BYTE_STROBE_EN.
// Latency: access on edge accept+WAIT_CYCLES+1, rspValid high the cycle after; one transaction in flight.
// Backpressure: reqReady only in IDLE; response held stable in RESP until rspReady.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = DMEM_DEPTH_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWr,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  reqBe,
`endif
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspRdata,
    output logic        rspErr,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t                state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t             req_q, req_d;
    logic                  err_q, err_d;
    logic                  rd_sel_q, rd_sel_d;

    logic        accept;
    logic        access;
    logic        in_range;
    logic [31:0] arr_rdata;

    assign accept   = (state_q == ST_IDLE) && reqValid;
    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    // Full 32-bit compare so high address bits can never alias into the array.
    assign in_range = req_q.addr < 32'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (reqValid)      state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0)   state_d = ST_RESP;
            ST_RESP: if (rspReady)      state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reqReady = (state_q == ST_IDLE);
        rspValid = (state_q == ST_RESP);
        busy     = (state_q != ST_IDLE);
        rspErr   = err_q;
        rspRdata = rd_sel_q ? arr_rdata : '0;
    end

    always_comb begin
        req_d    = req_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        if (accept) begin
            req_d.wr    = reqWr;
            req_d.addr  = reqAddr;
            req_d.wdata = reqWdata;
`ifdef DMEM_BYTE_STROBE_EN
            req_d.be    = reqBe;
`else
            req_d.be    = 4'hF;
`endif
            cnt_d       = DMEM_CNT_W'(WAIT_CYCLES);
        end else if (state_q == ST_WAIT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DMEM_CNT_W'(1);
            end else begin
                err_d    = !in_range;
                rd_sel_d = in_range && !req_q.wr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (access && in_range),
        .we    (req_q.wr),
        .be    (req_q.be),
        .addr  (req_q.addr[AW-1:0]),
        .wdata (req_q.wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned W = 2;
    localparam int unsigned D = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWr;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [3:0]  reqBe;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(
        .DEPTH       (D),
        .WAIT_CYCLES (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqWr    (reqWr),
        .reqAddr  (reqAddr),
        .reqWdata (reqWdata),
`ifdef DMEM_BYTE_STROBE_EN
        .reqBe    (reqBe),
`endif
        .rspValid (rspValid),
        .rspReady (rspReady),
        .rspRdata (rspRdata),
        .rspErr   (rspErr),
        .busy     (busy)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [3:0]  m;
        logic [31:0] r;
`ifdef DMEM_BYTE_STROBE_EN
        m = be;
`else
        m = be | 4'hF;
`endif
        r = old_w;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Expected response for one request, updating the model for in-range stores.
    task automatic model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] exp_rdata, output logic exp_err);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        if (addr >= D) begin
            exp_err = 1'b1;
        end else if (wr) begin
            model[addr] = merge(model.exists(addr) ? model[addr] : 32'h0, wdata, be);
        end else begin
            exp_rdata = model.exists(addr) ? model[addr] : 32'h0;
        end
    endtask

    // Full request/response transaction; rspReady held low for 'stall' cycles once the response is up.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall,
                       output logic [31:0] rdata, output logic err, output int lat, output int acc);
        int n;
        reqWr    = wr;
        reqAddr  = addr;
        reqWdata = wdata;
        reqBe    = be;
        reqValid = 1'b1;
        rspReady = (stall == 0);
        n = 0;
        while (reqReady !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        acc      = cyc;
        reqValid = 1'b0;
        lat = 0;
        while (rspValid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        rdata    = rspRdata;
        err      = rspErr;
        rspReady = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; reqValid = 1'b0; reqWr = 1'b0; reqAddr = '0; reqWdata = '0; reqBe = 4'hF;
        rspReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({reqReady, rspValid, rspRdata, rspErr, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
                     reqReady, rspValid, rspRdata, rspErr, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_preload;
        logic [31:0] rd, er;
        logic        e, ee;
        int          lat, acc;
        for (int a = 0; a < 16; a++) begin
            model_apply(1'b1, a, (a == 5) ? 32'hDEADBEEF : ((a == 7) ? 32'h0 : $urandom), 4'hF, er, ee);
            txn(1'b1, a, model[a], 4'hF, 0, rd, e, lat, acc);
        end
        for (int a = 0; a < 8; a++) begin
            model_apply(1'b1, D - 8 + a, $urandom, 4'hF, er, ee);
            txn(1'b1, D - 8 + a, model[D - 8 + a], 4'hF, 0, rd, e, lat, acc);
        end
        model_apply(1'b1, 100, 32'h0, 4'hF, er, ee);
        txn(1'b1, 100, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== er || e !== ee || lat != W + 1) begin
            errors++;
            $display("FAIL preload_store_rsp: got rdata=%h err=%b lat=%0d, want %h %b %0d",
                     rd, e, lat, er, ee, W + 1);
        end
    endtask

    task automatic test_load;
        logic [31:0] rd;
        logic        e;
        int          lat, acc;
        txn(1'b0, 5, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (lat != W + 1) begin
            errors++; $display("FAIL load_latency: got %0d cycles, want %0d", lat, W + 1);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL load_word5: got rdata=%h err=%b, want deadbeef 0", rd, e);
        end
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++; $display("FAIL load_handshake: got vld=%b rdy=%b, want 0 1", rspValid, reqReady);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd, er;
        logic        e, ee;
        int          lat, acc;
        model_apply(1'b1, 100, 32'h12345678, 4'hF, er, ee);
        txn(1'b1, 100, 32'h12345678, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL store_ack: got rdata=%h err=%b, want 0 0", rd, e);
        end
        txn(1'b0, 100, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            errors++; $display("FAIL store_then_load: got rdata=%h err=%b, want 12345678 0", rd, e);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd, er;
        logic        e, ee;
        int          lat, acc;
        model_apply(1'b1, D, 32'hCAFEF00D, 4'hF, er, ee);
        txn(1'b1, D, 32'hCAFEF00D, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL oor_store: got rdata=%h err=%b, want 0 1", rd, e);
        end
        txn(1'b0, D, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL oor_load: got rdata=%h err=%b, want 0 1", rd, e);
        end
        txn(1'b0, 0, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== model[0] || e !== 1'b0) begin
            errors++; $display("FAIL oor_word0: got rdata=%h err=%b, want %h 0", rd, e, model[0]);
        end
        txn(1'b0, D - 1, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== model[D - 1] || e !== 1'b0) begin
            errors++; $display("FAIL oor_wordlast: got rdata=%h err=%b, want %h 0", rd, e, model[D - 1]);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp;
        int          n;
        exp = model[5];
        reqWr = 1'b0; reqAddr = 5; reqValid = 1'b1; rspReady = 1'b0;
        @(posedge clk); #1;
        reqValid = 1'b0;
        n = 0;
        while (rspValid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rspValid !== 1'b1 || rspRdata !== exp || reqReady !== 1'b0 || rspErr !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b rdata=%h rdy=%b err=%b, want 1 %h 0 0",
                         i, rspValid, rspRdata, reqReady, rspErr, exp);
            end
            if (i == 1) begin reqValid = 1'b1; reqWr = 1'b1; reqAddr = 9; reqWdata = 32'hBAD0BAD0; end
            if (i == 2) reqValid = 1'b0;
            @(posedge clk); #1;
        end
        rspReady = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, want 0 1 0", rspValid, reqReady, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_ignored_pulse: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        e;
        int          lat, acc0, acc1, acc2;
        txn(1'b0, 1, 32'h0, 4'hF, 0, rd, e, lat, acc0);
        txn(1'b0, 2, 32'h0, 4'hF, 0, rd, e, lat, acc1);
        txn(1'b0, 3, 32'h0, 4'hF, 0, rd, e, lat, acc2);
        checks++;
        if (acc1 - acc0 != W + 3 || acc2 - acc1 != W + 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d edges, want %0d", acc1 - acc0, acc2 - acc1, W + 3);
        end
        checks++;
        if (rd !== model[3]) begin
            errors++; $display("FAIL b2b_data: got %h, want %h", rd, model[3]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        e;
        int          lat, acc;
        reqWr = 1'b1; reqAddr = 7; reqWdata = 32'hAAAA5555; reqBe = 4'hF; reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({reqReady, rspValid, rspRdata, rspErr, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
                     reqReady, rspValid, rspRdata, rspErr, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 7, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL midreset_no_commit: got rdata=%h err=%b, want 0 0", rd, e);
        end
    endtask

`ifdef DMEM_BYTE_STROBE_EN
    task automatic test_byte_strobe;
        logic [31:0] rd, er;
        logic        e, ee;
        int          lat, acc;
        model_apply(1'b1, 3, 32'h11223344, 4'hF, er, ee);
        txn(1'b1, 3, 32'h11223344, 4'hF, 0, rd, e, lat, acc);
        model_apply(1'b1, 3, 32'hAABBCCDD, 4'b0101, er, ee);
        txn(1'b1, 3, 32'hAABBCCDD, 4'b0101, 0, rd, e, lat, acc);
        txn(1'b0, 3, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++; $display("FAIL strobe_0101: got %h, want 11bb33dd", rd);
        end
        txn(1'b1, 3, 32'hFFFFFFFF, 4'b0000, 0, rd, e, lat, acc);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL strobe_zero_ack: got rdata=%h err=%b, want 0 0", rd, e);
        end
        txn(1'b0, 3, 32'h0, 4'hF, 0, rd, e, lat, acc);
        checks++;
        if (rd !== model[3]) begin
            errors++; $display("FAIL strobe_zero_nochange: got %h, want %h", rd, model[3]);
        end
    endtask
`endif

    task automatic test_random;
        logic [31:0] rd, er, addr, wdata;
        logic [3:0]  be;
        logic        e, ee, wr;
        int          lat, acc, stall;
        for (int i = 0; i < 60; i++) begin
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            stall = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0, 1:    addr = $urandom_range(0, 15);
                2:       addr = D - 8 + $urandom_range(0, 7);
                3:       addr = D + $urandom_range(0, 3);
                default: addr = 32'h8000_0000 | $urandom_range(0, 15);
            endcase
            model_apply(wr, addr, wdata, be, er, ee);
            txn(wr, addr, wdata, be, stall, rd, e, lat, acc);
            checks++;
            if (rd !== er || e !== ee || lat != W + 1) begin
                errors++;
                $display("FAIL random_%0d: wr=%b addr=%h got rdata=%h err=%b lat=%0d, want %h %b %0d",
                         i, wr, addr, rd, e, lat, er, ee, W + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_load();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_BYTE_STROBE_EN
        test_byte_strobe();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
